// File: rtl/irq_timer.sv
// Programmable interval timer: one-shot or auto-reload countdown from PRESET,
// raising a maskable interrupt when COUNT expires.
module irq_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'd1;

    state_t      state, stateNext;
    logic [3:0]  ctrl, ctrlNext;
    logic [31:0] preset, presetNext;
    logic [31:0] count, countNext;
    logic        flag, flagNext;

    logic ctrlWrite;
    logic presetWrite;

    assign ctrlWrite   = we && (addr == ADDR_CTRL);
    assign presetWrite = we && (addr == ADDR_PRESET);

    // Bus writes to CTRL/PRESET win over the FSM and park it in IDLE.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        stateNext  = state;
        ctrlNext   = ctrl;
        presetNext = preset;
        countNext  = count;
        flagNext   = flag;

        if (ctrlWrite || presetWrite) begin
            if (ctrlWrite)   ctrlNext   = wd[3:0];
            if (presetWrite) presetNext = wd;
            stateNext = IDLE;
            flagNext  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl[0]) stateNext = LOAD;
                end
                LOAD: begin
                    countNext = preset;
                    stateNext = CNT;
                end
                CNT: begin
                    if (count > 32'd1) begin
                        countNext = count - 32'd1;
                    end else begin
                        countNext = 32'd0;
                        flagNext  = 1'b1;
                        stateNext = INT;
                    end
                end
                INT: begin
                    if (ctrl[2:1] == MODE_RELOAD) begin
                        flagNext  = 1'b0;
                        stateNext = LOAD;
                    end else begin
                        ctrlNext[0] = 1'b0;
                        stateNext   = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all updates land together at the edge.
        if (reset) begin
            state  <= IDLE;
            ctrl   <= 4'd0;
            preset <= 32'd0;
            count  <= 32'd0;
            flag   <= 1'b0;
        end else begin
            state  <= stateNext;
            ctrl   <= ctrlNext;
            preset <= presetNext;
            count  <= countNext;
            flag   <= flagNext;
        end
    end

    always_comb begin
        rd = 32'd0;
        case (addr)
            ADDR_CTRL:   rd = {28'd0, ctrl};
            ADDR_PRESET: rd = preset;
            ADDR_COUNT:  rd = count;
            default:     rd = 32'd0;
        endcase
    end

    // Both operands are flops, so irq has no path from the bus inputs.
    assign irq = flag & ctrl[3];

endmodule
